// File: rtl/alu_operand_issue_pkg.sv
// rtl/alu_operand_issue_pkg.sv - ALUop codes and operand-select constants shared by the issue stage
package alu_operand_issue_pkg;

  // ALUop encodings shared with the ALU
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_BEQ  = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALUNULL  = 4'hF;

  // A operand select; code 3 is reserved and yields zero
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // B operand select; code 3 is reserved and yields zero
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/alu_operand_issue_fwd_select.sv
// rtl/alu_operand_issue_fwd_select.sv - per-operand forwarding priority: x0, then MEM, then WB, then register file
module alu_operand_issue_fwd_select #(
  parameter int XLEN   = 32,
  parameter int REGIDX = 5
) (
  input  logic [REGIDX-1:0] rs,
  input  logic [XLEN-1:0]   rf_val,
  input  logic              mem_we,
  input  logic [REGIDX-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_val,
  input  logic              wb_we,
  input  logic [REGIDX-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  output logic [XLEN-1:0]   val
);

  // x0 always reads zero and is never a forwarding target; the younger producer wins
  always_comb begin
    val = rf_val;
    if (rs == '0)
      val = '0;
    else if (mem_we && (mem_rd == rs))
      val = mem_val;
    else if (wb_we && (wb_rd == rs))
      val = wb_val;
  end

endmodule

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - decode/execute holding register with operand forwarding; ALU_ISSUE_STATS_EN adds stall/flush/issue counters
module alu_operand_issue
  import alu_operand_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aluop,
  input  logic [REGIDX-1:0] in_rs1,
  input  logic [REGIDX-1:0] in_rs2,
  input  logic [REGIDX-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [1:0]        in_src_a,
  input  logic [1:0]        in_src_b,
  input  logic              flush,
  input  logic              mem_we,
  input  logic [REGIDX-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_val,
  input  logic              wb_we,
  input  logic [REGIDX-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_aluop,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [REGIDX-1:0] out_rd
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       issue_cnt
`endif
);

  logic              valid_q;
  logic [3:0]        aluop_q;
  logic [REGIDX-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   rs1_val_q, rs2_val_q, pc_q, imm_q;
  logic [1:0]        src_a_q, src_b_q;

  logic [XLEN-1:0]   cap_rs1_val, cap_rs2_val;
  logic [XLEN-1:0]   ref_rs1_val, ref_rs2_val;
  logic              capture, consume, stalled;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign consume  = valid_q && out_ready;
  assign stalled  = valid_q && !out_ready;

  alu_operand_issue_fwd_select #(.XLEN(XLEN), .REGIDX(REGIDX)) u_fwd_rs1 (
    .rs(in_rs1), .rf_val(in_rs1_val),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_val(mem_val),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .val(cap_rs1_val)
  );

  alu_operand_issue_fwd_select #(.XLEN(XLEN), .REGIDX(REGIDX)) u_fwd_rs2 (
    .rs(in_rs2), .rf_val(in_rs2_val),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_val(mem_val),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .val(cap_rs2_val)
  );

  // Refresh of held operands: only WB can still be in flight behind a stalled entry, so MEM is tied off
  alu_operand_issue_fwd_select #(.XLEN(XLEN), .REGIDX(REGIDX)) u_ref_rs1 (
    .rs(rs1_q), .rf_val(rs1_val_q),
    .mem_we(1'b0), .mem_rd('0), .mem_val('0),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .val(ref_rs1_val)
  );

  alu_operand_issue_fwd_select #(.XLEN(XLEN), .REGIDX(REGIDX)) u_ref_rs2 (
    .rs(rs2_q), .rf_val(rs2_val_q),
    .mem_we(1'b0), .mem_rd('0), .mem_val('0),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .val(ref_rs2_val)
  );

  // Holding register: flush beats capture beats consume; a stalled entry picks up WB results
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALUNULL;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      src_a_q   <= SRC_A_RS1;
      src_b_q   <= SRC_B_RS2;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q   <= 1'b1;
        aluop_q   <= in_aluop;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        rd_q      <= in_rd;
        rs1_val_q <= cap_rs1_val;
        rs2_val_q <= cap_rs2_val;
        pc_q      <= in_pc;
        imm_q     <= in_imm;
        src_a_q   <= in_src_a;
        src_b_q   <= in_src_b;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      if (stalled) begin
        rs1_val_q <= ref_rs1_val;
        rs2_val_q <= ref_rs2_val;
      end
    end
  end

  // Operand muxes sit after the holding register so refreshed values reach the ALU
  always_comb begin
    case (src_a_q)
      SRC_A_RS1: out_a = rs1_val_q;
      SRC_A_PC:  out_a = pc_q;
      default:   out_a = '0;
    endcase
    case (src_b_q)
      SRC_B_RS2:  out_b = rs2_val_q;
      SRC_B_IMM:  out_b = imm_q;
      SRC_B_FOUR: out_b = XLEN'(4);
      default:    out_b = '0;
    endcase
  end

  assign out_valid      = valid_q;
  assign out_aluop      = valid_q ? aluop_q : ALUNULL;
  assign out_store_data = rs2_val_q;
  assign out_pc         = pc_q;
  assign out_imm        = imm_q;
  assign out_rd         = rd_q;

`ifdef ALU_ISSUE_STATS_EN
  // Event counters; a flush overrides a same-cycle consume so that is not counted as an issue
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stalled)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && valid_q)
        flush_cnt <= flush_cnt + 32'd1;
      if (consume && !flush)
        issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule
